zero_window_counter: RTL and testbench
======================================

ZERO_WINDOW_COUNTER -- requirements
Module: zero_window_counter

Interface
REQ-001 SHALL have parameter WINDOW, default 16, window length in clock cycles (legal range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 8, count width in bits (legal range 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port start, input, 1, arms one counting window; sampled only in IDLE and in HOLD on handshake.
REQ-006 SHALL have port det, input, 1, one-cycle detection pulse from the upstream zero-sequence detector.
REQ-007 SHALL have port busy, output, 1, high while in COUNT.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-010 SHALL have port out_count, output, CNT_W, number of det pulses in the last window.
REQ-011 SHALL have port overflow, output, 1, out_count saturated during the window.

Function
REQ-012 SHALL implement FSM states IDLE, COUNT, HOLD.
REQ-013 IDLE: start=1 -> COUNT next cycle; window counter loads WINDOW-1; count and overflow clear to 0.
REQ-014 COUNT: each cycle with det=1 increments count by 1; det in the start cycle is not counted.
REQ-015 Count SHALL saturate at 2^CNT_W-1; any det at saturation sets overflow, which stays set until the next window starts.
REQ-016 COUNT lasts exactly WINDOW cycles; det in the final cycle is counted; -> HOLD after the final cycle.
REQ-017 HOLD: out_valid=1; out_count and overflow stable until handshake (out_valid & out_ready).
REQ-018 Handshake with start=1 -> COUNT directly (back-to-back window, zero gap); handshake with start=0 -> IDLE.
REQ-019 det SHALL be ignored in IDLE and HOLD.
REQ-020 start SHALL be ignored in COUNT and in HOLD without handshake.
REQ-021 out_valid SHALL be 0 outside HOLD; busy SHALL be 0 outside COUNT.
REQ-022 out_count and overflow SHALL be registered outputs, with no combinational path from det.
REQ-023 Result latency: out_valid rises the cycle after the last window cycle.

Reset
REQ-024 reset=0 SHALL immediately force IDLE, count=0, window counter=0, out_valid=0, busy=0, out_count=0, overflow=0.
REQ-025 Reset mid-COUNT or mid-HOLD SHALL discard the partial or pending result; no out_valid after release until a new window completes.
REQ-026 First start is sampled on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro ZERO_WINDOW_COUNTER_AUTO_RESTART_EN defined: on the HOLD handshake the block re-enters COUNT regardless of start (continuous windows); start is used only to leave IDLE.
REQ-028 Macro not defined: behaviour is exactly REQ-018.

Structure
REQ-029 Shared package zero_pkg SHALL hold the FSM state enum (IDLE/COUNT/HOLD) and default constants ZWC_WINDOW_DEF=16 and ZWC_CNT_W_DEF=8.
REQ-030 The window down-counter SHALL be a sub-module zero_window_timer (load, enable, done outputs); everything else is in zero_window_counter.

Verification (WINDOW=8, CNT_W=4 unless noted)
REQ-031 start pulse, det high on window cycles 1, 3, 8 (the final cycle), out_ready=1 -> out_valid for 1 cycle, out_count=3, overflow=0.
REQ-032 CNT_W=2, det high all 8 window cycles -> out_count=3, overflow=1; the next window with 1 det -> out_count=1, overflow=0.
REQ-033 out_ready=0 for 5 cycles in HOLD while det toggles -> out_valid held 5+ cycles, out_count unchanged; accepted on the cycle out_ready=1.
REQ-034 start=1 held at handshake -> busy rises the next cycle with no IDLE gap; the second window is counted independently.
REQ-035 reset=0 asserted asynchronously mid-COUNT after 4 dets -> all outputs 0 immediately; after release with no start -> out_valid stays 0 for 20 cycles.
REQ-036 AUTO_RESTART_EN defined, single start, out_ready=1 -> out_valid pulses every 9 cycles indefinitely.

Source files
------------

// File: rtl/zero_pkg.sv
// Shared FSM state type and default sizing for the zero-window counter.
package zero_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } zwc_state_t;

   localparam int unsigned ZWC_WINDOW_DEF = 16;
   localparam int unsigned ZWC_CNT_W_DEF  = 8;
   localparam int unsigned ZWC_TIMER_W    = 16;

endpackage

// File: rtl/zero_window_timer.sv
// Window down-counter: loads WINDOW-1, decrements while enabled, flags done at zero.
module zero_window_timer
   import zero_pkg::*;
#(
   parameter int unsigned WINDOW = ZWC_WINDOW_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic enable,
   output logic done
);

   localparam logic [ZWC_TIMER_W-1:0] LOAD_VAL = ZWC_TIMER_W'(WINDOW - 1);

   logic [ZWC_TIMER_W-1:0] r_remain;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_remain <= '0;
      end else if (load) begin
         r_remain <= LOAD_VAL;
      end else if (enable && (r_remain != '0)) begin
         r_remain <= r_remain - ZWC_TIMER_W'(1);
      end
   end

   // done is asserted during the last cycle of the window
   assign done = (r_remain == '0);

endmodule

// File: rtl/zero_window_counter.sv
// Counts det pulses over a WINDOW-cycle window and holds the result until accepted.
// Define ZERO_WINDOW_COUNTER_AUTO_RESTART_EN for continuous back-to-back windows.
module zero_window_counter
   import zero_pkg::*;
#(
   parameter int unsigned WINDOW = ZWC_WINDOW_DEF,
   parameter int unsigned CNT_W  = ZWC_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             det,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   zwc_state_t       r_state;
   zwc_state_t       w_state_nxt;
   logic             w_load;
   logic             w_enable;
   logic             w_done;
   logic             w_hs;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;

   zero_window_timer #(
      .WINDOW (WINDOW)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (w_load),
      .enable (w_enable),
      .done   (w_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_enable    = 1'b0;
      w_hs        = (r_state == HOLD) && out_ready;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = COUNT;
               w_load      = 1'b1;
            end
         end
         COUNT: begin
            w_enable = 1'b1;
            if (w_done) begin
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (w_hs) begin
`ifdef ZERO_WINDOW_COUNTER_AUTO_RESTART_EN
               w_state_nxt = COUNT;
               w_load      = 1'b1;
`else
               if (start) begin
                  w_state_nxt = COUNT;
                  w_load      = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
`endif
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Count clears on every window load; it only moves in COUNT, so it is frozen in HOLD
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_load) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if ((r_state == COUNT) && det) begin
         if (r_count == CNT_MAX) begin
            r_overflow <= 1'b1;
         end else begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign busy      = (r_state == COUNT);
   assign out_valid = (r_state == HOLD);
   assign out_count = r_count;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_zero_window_counter.sv
// Self-checking bench: two instances (CNT_W=4 and CNT_W=2) share stimulus and a window-level model.
module tb_zero_window_counter;

   localparam int unsigned W = 8;
   localparam int MAX_A = 15;
   localparam int MAX_B = 3;
`ifdef ZERO_WINDOW_COUNTER_AUTO_RESTART_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       det;
   logic       out_ready;
   logic       busy_a, valid_a, ovf_a;
   logic [3:0] cnt_a;
   logic       busy_b, valid_b, ovf_b;
   logic [1:0] cnt_b;

   int checks = 0;
   int errors = 0;

   // model: cycles left in the open window, true det total, result pending
   int m_left;
   int m_dets;
   bit m_pend;

   always #5 clk = ~clk;

   zero_window_counter #(.WINDOW(W), .CNT_W(4)) u_dut_a (
      .clk(clk), .reset(reset), .start(start), .det(det),
      .busy(busy_a), .out_valid(valid_a), .out_ready(out_ready),
      .out_count(cnt_a), .overflow(ovf_a)
   );

   zero_window_counter #(.WINDOW(W), .CNT_W(2)) u_dut_b (
      .clk(clk), .reset(reset), .start(start), .det(det),
      .busy(busy_b), .out_valid(valid_b), .out_ready(out_ready),
      .out_count(cnt_b), .overflow(ovf_b)
   );

   function automatic int sat(input int n, input int mx);
      return (n > mx) ? mx : n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_left = 0;
      m_dets = 0;
      m_pend = 1'b0;
   endtask

   task automatic model_edge();
      if (m_left > 0) begin
         if (det) m_dets++;
         m_left--;
         if (m_left == 0) m_pend = 1'b1;
      end else if (m_pend) begin
         if (out_ready) begin
            m_pend = 1'b0;
            if (start || AUTO) begin
               m_left = W;
               m_dets = 0;
            end
         end
      end else if (start) begin
         m_left = W;
         m_dets = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/busy_a"},  busy_a,  int'(m_left > 0));
      chk({tag, "/valid_a"}, valid_a, int'(m_pend));
      chk({tag, "/cnt_a"},   cnt_a,   sat(m_dets, MAX_A));
      chk({tag, "/ovf_a"},   ovf_a,   int'(m_dets > MAX_A));
      chk({tag, "/busy_b"},  busy_b,  int'(m_left > 0));
      chk({tag, "/valid_b"}, valid_b, int'(m_pend));
      chk({tag, "/cnt_b"},   cnt_b,   sat(m_dets, MAX_B));
      chk({tag, "/ovf_b"},   ovf_b,   int'(m_dets > MAX_B));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // asserts reset between edges, checks outputs at once, releases on the falling edge
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      det   = 1'b0;
   endtask

   initial begin
      int held;
      int last;
      int seen;
      reset     = 1'b1;
      start     = 1'b0;
      det       = 1'b0;
      out_ready = 1'b0;
      model_reset();
      #2;
      reset = 1'b0;
      #2;
      check_all("reset");
      @(negedge clk);
      reset = 1'b1;

      // window with dets on cycles 1, 3 and the final cycle
      start     = 1'b1;
      out_ready = 1'b1;
      tick("r031_start");
      chk("r031_busy", busy_a, 1);
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         det = (k == 1) || (k == 3) || (k == 8);
         tick("r031_win");
      end
      det = 1'b0;
      chk("r031_valid", valid_a, 1);
      chk("r031_cnt", cnt_a, 3);
      chk("r031_ovf", ovf_a, 0);
      tick("r031_hs");
      chk("r031_vdrop", valid_a, 0);
      async_reset("r031_rst");

      // saturation on the narrow instance, then back-to-back window
      start = 1'b1;
      tick("r032_start");
      start = 1'b0;
      det   = 1'b1;
      repeat (8) tick("r032_win");
      det = 1'b0;
      chk("r032_cnt_b", cnt_b, 3);
      chk("r032_ovf_b", ovf_b, 1);
      chk("r032_cnt_a", cnt_a, 8);
      chk("r032_ovf_a", ovf_a, 0);
      out_ready = 1'b1;
      start     = 1'b1;
      tick("r034_hs");
      chk("r034_busy", busy_a, 1);
      chk("r034_valid", valid_a, 0);
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         det = (k == 5);
         tick("r034_win");
      end
      det = 1'b0;
      chk("r034_valid_b", valid_b, 1);
      chk("r034_cnt_b", cnt_b, 1);
      chk("r034_ovf_b", ovf_b, 0);
      async_reset("r034_rst");

      // stalled handshake with det and start toggling in HOLD
      start     = 1'b1;
      out_ready = 1'b0;
      tick("r033_start");
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         det = k[0];
         tick("r033_win");
      end
      chk("r033_cnt", cnt_a, 4);
      held = int'(cnt_a);
      for (int s = 0; s < 5; s++) begin
         det   = s[0];
         start = 1'b1;
         tick("r033_stall");
         chk("r033_valid", valid_a, 1);
         chk("r033_held", cnt_a, held);
         chk("r033_busy", busy_a, 0);
      end
      start     = 1'b0;
      det       = 1'b0;
      out_ready = 1'b1;
      tick("r033_hs");
      chk("r033_vdrop", valid_a, 0);
      async_reset("r033_rst");

      // reset mid-COUNT discards the partial window
      start = 1'b1;
      tick("r035_start");
      start = 1'b0;
      det   = 1'b1;
      repeat (4) tick("r035_win");
      det = 1'b0;
      chk("r035_cnt", cnt_a, 4);
      async_reset("r035_rst");
      for (int c = 0; c < 20; c++) begin
         det = 1'($urandom % 2);
         tick("r035_idle");
         chk("r035_novalid", valid_a, 0);
      end

`ifdef ZERO_WINDOW_COUNTER_AUTO_RESTART_EN
      start     = 1'b1;
      out_ready = 1'b1;
      tick("r036_start");
      start = 1'b0;
      last  = -1;
      seen  = 0;
      for (int c = 0; c < 45; c++) begin
         det = 1'($urandom % 2);
         tick("r036_run");
         if (valid_a === 1'b1) begin
            if (last >= 0) chk("r036_period", c - last, 9);
            last = c;
            seen++;
         end
      end
      chk("r036_pulses", seen, 5);
      async_reset("r036_rst");
`endif

      for (int i = 0; i < 600; i++) begin
         start     = ($urandom % 4) == 0;
         det       = 1'($urandom % 2);
         out_ready = ($urandom % 3) != 0;
         if (($urandom % 150) == 0) async_reset("rand_rst");
         else tick("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
